// File: rtl/pixel_pkg.sv
// Shared types and constants for the canvas RAM scheduler and its write queue.
package pixel_pkg;

  typedef enum logic [1:0] {
    RAM_INIT  = 2'd0,
    RAM_RUN   = 2'd1,
    RAM_CLEAR = 2'd2
  } ram_state_e;

  localparam int CANVAS_WORDS = 16384;

  localparam logic [2:0] COLOR_ERASE = 3'b000;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_RED   = 3'b100;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

endpackage

// File: rtl/pixel_write_fifo.sv
// Brush write queue: power-of-two depth, head visible combinationally, flush and
// reset both empty it; the caller guarantees no push when full and no pop when empty.
module pixel_write_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[PW-1:0]] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q[PW-1:0]];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/pixel_ram_scheduler.sv
// Time-shares the single-port canvas RAM: even cycles serve display reads, odd cycles
// serve clear sweeps or queued brush writes; pixColor lands 2 cycles after its read slot.
module pixel_ram_scheduler import pixel_pkg::*; #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [2:0] CLEAR_COLOR = COLOR_ERASE,
  parameter int         CANVAS_BITS = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CANVAS_BITS-1:0]   rdX,
  input  logic [CANVAS_BITS-1:0]   rdY,
  input  logic                     wrValid,
  output logic                     wrReady,
  input  logic [CANVAS_BITS-1:0]   wrX,
  input  logic [CANVAS_BITS-1:0]   wrY,
  input  logic [2:0]               wrColor,
  input  logic                     clearReq,
  output logic                     busy,
  output logic [2:0]               pixColor,
  output logic                     pixValid,
  output logic [2*CANVAS_BITS-1:0] ramAdr,
  output logic                     ramWE,
  output logic [15:0]              ramWriteData,
  input  logic [15:0]              ramData
);

  localparam int AW = 2 * CANVAS_BITS;
  localparam int EW = AW + 3;

  ram_state_e    state_q, state_d;
  logic          slot_q, slot_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          rd_pend_q, rd_pend_d;
  logic          pix_vld_q, pix_vld_d;
  logic [2:0]    pix_color_q, pix_color_d;

  logic          write_slot;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_flush;
  logic [EW-1:0] head_dat;
  logic          unused_ram_hi;

  assign write_slot = slot_q;
  assign fifo_flush = (state_q == RAM_RUN) && clearReq;
  // Ready ignores this cycle's pop so the valid/ready path never loops through the RAM slot logic.
  assign wrReady    = (state_q == RAM_RUN) && !fifo_full && !clearReq;
  assign fifo_push  = wrValid && wrReady;
  assign fifo_pop   = (state_q == RAM_RUN) && write_slot && !fifo_empty && !clearReq;

  pixel_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_dat ({wrY, wrX, wrColor}),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    ramAdr       = '0;
    ramWE        = 1'b0;
    ramWriteData = '0;
    if (!write_slot) begin
      ramAdr = {rdY, rdX};
    end else if (state_q != RAM_RUN) begin
      ramAdr       = cnt_q;
      ramWE        = 1'b1;
      ramWriteData = {13'b0, CLEAR_COLOR};
    end else if (fifo_pop) begin
      ramAdr       = head_dat[EW-1:3];
      ramWE        = 1'b1;
      ramWriteData = {13'b0, head_dat[2:0]};
    end
  end

  always_comb begin
    slot_d  = ~slot_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      RAM_INIT, RAM_CLEAR: begin
        if (write_slot) begin
          cnt_d = cnt_q + AW'(1);
          if (&cnt_q) begin
            state_d = RAM_RUN;
            busy_d  = 1'b0;
          end
        end
      end
      RAM_RUN: begin
        if (clearReq) begin
          state_d = RAM_CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RAM_INIT;
        busy_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase

    // RAM output is valid the cycle after a read slot; register it one more time.
    rd_pend_d   = !write_slot;
    pix_vld_d   = rd_pend_q;
    pix_color_d = rd_pend_q ? ramData[2:0] : pix_color_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RAM_INIT;
      slot_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      rd_pend_q   <= 1'b0;
      pix_vld_q   <= 1'b0;
      pix_color_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      rd_pend_q   <= rd_pend_d;
      pix_vld_q   <= pix_vld_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign busy          = busy_q;
  assign pixColor      = pix_color_q;
  assign pixValid      = pix_vld_q;
  assign unused_ram_hi = ^ramData[15:3];

endmodule

// File: tb/tb_pixel_ram_scheduler.sv
// Directed bench for pixel_ram_scheduler with a behavioural single-port RAM attached.
module tb_pixel_ram_scheduler;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [6:0]  rdX      = 7'd0;
  logic [6:0]  rdY      = 7'd0;
  logic        wrValid  = 1'b0;
  logic [6:0]  wrX      = 7'd0;
  logic [6:0]  wrY      = 7'd0;
  logic [2:0]  wrColor  = 3'd0;
  logic        clearReq = 1'b0;
  logic        wrReady, busy, pixValid, ramWE;
  logic [2:0]  pixColor;
  logic [13:0] ramAdr;
  logic [15:0] ramWriteData;
  logic [15:0] ramData = 16'h0000;

  logic [15:0] mem [16384] = '{default: 16'h0005};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int sweep_id = 1;
  int sw_n     = 0;
  int sw_dup   = 0;
  int sw_bad   = 0;
  int wid [16384];
  logic [13:0] bw_adr [64];
  logic [15:0] bw_dat [64];
  int          bw_cyc [64];
  int          bw_n = 0;

  typedef struct {
    logic [6:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         adr;
    int         pix;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  pixel_ram_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .rdX          (rdX),
    .rdY          (rdY),
    .wrValid      (wrValid),
    .wrReady      (wrReady),
    .wrX          (wrX),
    .wrY          (wrY),
    .wrColor      (wrColor),
    .clearReq     (clearReq),
    .busy         (busy),
    .pixColor     (pixColor),
    .pixValid     (pixValid),
    .ramAdr       (ramAdr),
    .ramWE        (ramWE),
    .ramWriteData (ramWriteData),
    .ramData      (ramData)
  );

  always @(posedge clk) begin
    if (ramWE) mem[ramAdr] <= ramWriteData;
    else       ramData     <= mem[ramAdr];
  end

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Sweep writes are tallied per sweep; brush writes are logged in order.
  always @(negedge clk) begin
    if (!reset && ramWE) begin
      if (busy) begin
        sw_n <= sw_n + 1;
        if (wid[ramAdr] == sweep_id) sw_dup <= sw_dup + 1;
        wid[ramAdr] <= sweep_id;
        if (ramWriteData != 16'h0000) sw_bad <= sw_bad + 1;
      end else if (bw_n < 64) begin
        bw_adr[bw_n] <= ramAdr;
        bw_dat[bw_n] <= ramWriteData;
        bw_cyc[bw_n] <= cyc;
        bw_n         <= bw_n + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_read_slot();
    @(negedge clk);
    while (cyc[0]) @(negedge clk);
  endtask

  task automatic check_read(input logic [6:0] x, input logic [6:0] y, input int exp, input string name);
    wait_read_slot();
    rdX = x;
    rdY = y;
    tick();
    tick();
    chk({name, "_vld"}, int'(pixValid), 1);
    chk(name, int'(pixColor), exp);
  endtask

  initial begin
    int n, b0, b1, stalls, guard, early, s_n, s_dup, s_bad;

    vt[0] = '{x: 7'd5,   y: 7'd3,   c: 3'b010, adr: 389,   pix: 2};
    vt[1] = '{x: 7'd0,   y: 7'd0,   c: 3'b111, adr: 0,     pix: 7};
    vt[2] = '{x: 7'd127, y: 7'd127, c: 3'b001, adr: 16383, pix: 1};
    vt[3] = '{x: 7'd10,  y: 7'd20,  c: 3'b100, adr: 2570,  pix: 4};
    vt[4] = '{x: 7'd127, y: 7'd0,   c: 3'b101, adr: 127,   pix: 5};
    vt[5] = '{x: 7'd0,   y: 7'd127, c: 3'b011, adr: 16256, pix: 3};
    vt[6] = '{x: 7'd5,   y: 7'd3,   c: 3'b110, adr: 389,   pix: 6};

    // First run: stopped by reset while writing sweep address 9000.
    rdX = 7'd127;
    rdY = 7'd127;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 18001; i++) tick();
    chk("a_we_9000", int'(ramWE), 1);
    chk("a_adr_9000", int'(ramAdr), 9000);
    chk("a_pix_pre", int'(pixColor), 5);
    reset = 1'b1;
    tick();
    chk("rst_busy", int'(busy), 1);
    chk("rst_wrready", int'(wrReady), 0);
    chk("rst_pixvalid", int'(pixValid), 0);
    chk("rst_pixcolor", int'(pixColor), 0);
    chk("rst_we", int'(ramWE), 0);
    reset = 1'b0;

    // Full INIT sweep with clear requests that must be ignored.
    sweep_id = 2;
    s_n   = sw_n;
    s_dup = sw_dup;
    s_bad = sw_bad;
    b0    = bw_n;
    early = 0;
    for (n = 1; n <= 32768; n++) begin
      tick();
      if (n == 1) begin
        chk("b_first_we", int'(ramWE), 1);
        chk("b_first_adr", int'(ramAdr), 0);
      end
      if (n == 2) begin
        chk("b_read_vld", int'(pixValid), 1);
        chk("b_read_pix", int'(pixColor), 5);
      end
      if (n == 100 || n == 20001) clearReq = 1'b1;
      if (n == 101 || n == 20002) clearReq = 1'b0;
      if (n == 32767) chk("b_last_adr", int'(ramAdr), 16383);
      if (n < 32768 && (!busy || wrReady)) early++;
      if (n == 32768) begin
        chk("b_busy_fall", int'(busy), 0);
        chk("b_wrready_rise", int'(wrReady), 1);
      end
    end
    chk("b_busy_held", early, 0);
    tick();
    tick();
    chk("b_sweep_writes", sw_n - s_n, 16384);
    chk("b_sweep_dups", sw_dup - s_dup, 0);
    chk("b_sweep_data", sw_bad - s_bad, 0);
    repeat (20) tick();
    chk("b_fifo_empty", bw_n - b0, 0);

    // Single writes followed by read-back of the same pixel.
    for (int i = 0; i < 7; i++) begin
      wait_read_slot();
      wrX     = vt[i].x;
      wrY     = vt[i].y;
      wrColor = vt[i].c;
      wrValid = 1'b1;
      chk("tbl_rdy", int'(wrReady), 1);
      tick();
      wrValid = 1'b0;
      chk("tbl_we", int'(ramWE), 1);
      chk("tbl_adr", int'(ramAdr), vt[i].adr);
      chk("tbl_dat", int'(ramWriteData), int'(vt[i].c));
      check_read(vt[i].x, vt[i].y, vt[i].pix, "tbl_pix");
    end

    // Back-to-back pushes: queue fills, ready drops, RAM drains 1 per 2 cycles.
    b0     = bw_n;
    stalls = 0;
    wait_read_slot();
    for (int k = 0; k < 10; k++) begin
      wrX     = 7'(20 + k);
      wrY     = 7'(40 + k);
      wrColor = 3'(k % 7 + 1);
      wrValid = 1'b1;
      guard   = 0;
      while (!wrReady && guard < 20) begin
        stalls++;
        guard++;
        tick();
      end
      tick();
    end
    wrValid = 1'b0;
    repeat (30) tick();
    chk("thr_stalls", stalls, 3);
    chk("thr_count", bw_n - b0, 10);
    for (int j = 0; j < 10; j++) begin
      chk("thr_adr", int'(bw_adr[b0 + j]), (40 + j) * 128 + 20 + j);
      chk("thr_dat", int'(bw_dat[b0 + j]), j % 7 + 1);
      if (j > 0) chk("thr_spacing", bw_cyc[b0 + j] - bw_cyc[b0 + j - 1], 2);
    end

    // Clear with 3 entries still queued: they are discarded, sweep follows.
    b0 = bw_n;
    wait_read_slot();
    for (int k = 0; k < 5; k++) begin
      wrX     = 7'(60 + k);
      wrY     = 7'd10;
      wrColor = 3'(k + 1);
      wrValid = 1'b1;
      chk("clr_push_rdy", int'(wrReady), 1);
      tick();
    end
    wrValid  = 1'b0;
    clearReq = 1'b1;
    sweep_id = 3;
    s_n      = sw_n;
    s_dup    = sw_dup;
    s_bad    = sw_bad;
    #1;
    chk("clr_no_write", int'(ramWE), 0);
    chk("clr_rdy_low", int'(wrReady), 0);
    b1 = bw_n;
    tick();
    clearReq = 1'b0;
    chk("clr_busy", int'(busy), 1);
    n = 0;
    while (busy && n < 40000) begin
      tick();
      n++;
    end
    chk("clr_len", n, 32768);
    tick();
    tick();
    chk("clr_sweep_writes", sw_n - s_n, 16384);
    chk("clr_sweep_dups", sw_dup - s_dup, 0);
    chk("clr_sweep_data", sw_bad - s_bad, 0);
    chk("clr_pre_writes", b1 - b0, 2);
    chk("clr_pre_adr0", int'(bw_adr[b0]), 1340);
    chk("clr_pre_dat0", int'(bw_dat[b0]), 1);
    chk("clr_pre_adr1", int'(bw_adr[b0 + 1]), 1341);
    chk("clr_pre_dat1", int'(bw_dat[b0 + 1]), 2);
    repeat (10) tick();
    chk("clr_flushed", bw_n - b1, 0);
    check_read(7'd5, 7'd3, 0, "clr_pix");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
